// File: rtl/pkt_in_arbiter_pkg.sv
// Shared definitions for the packet input arbiter and its rotating-priority encoder.
package pkt_arb_pkg;

    localparam int PKT_BITS_DEFAULT = 72;
    localparam int MAX_INPUTS       = 8;

    function automatic int sel_bits_f(input int num_inputs);
        return (num_inputs > 1) ? $clog2(num_inputs) : 1;
    endfunction

    // Widest grant index any instance can need; instances narrow it to SEL_BITS.
    typedef logic [sel_bits_f(MAX_INPUTS)-1:0] grant_idx_t;

endpackage

// File: rtl/pkt_in_arbiter_if.sv
// Handshake bundle for the arbiter: NUM_INPUTS request streams in, one packet stream to the router.
interface pkt_in_arbiter_if
    import pkt_arb_pkg::*;
#(
    parameter int PACKET_BITS = PKT_BITS_DEFAULT,
    parameter int NUM_INPUTS  = 4
);

    logic [PACKET_BITS-1:0] pkt_in_data_in [NUM_INPUTS];
    logic                   pkt_in_vld_in  [NUM_INPUTS];
    logic                   pkt_in_rdy_out [NUM_INPUTS];
    logic [PACKET_BITS-1:0] pkt_out_data_out;
    logic                   pkt_out_vld_out;
    logic                   pkt_out_rdy_in;

    modport master (
        input  pkt_in_data_in, pkt_in_vld_in, pkt_out_rdy_in,
        output pkt_in_rdy_out, pkt_out_data_out, pkt_out_vld_out
    );

    modport slave (
        output pkt_in_data_in, pkt_in_vld_in, pkt_out_rdy_in,
        input  pkt_in_rdy_out, pkt_out_data_out, pkt_out_vld_out
    );

endinterface

// File: rtl/pkt_in_arbiter_rr_grant.sv
// Combinational rotating-priority encoder: grants the first masked requester after ptr, wrapping at N-1.
module rr_grant
    import pkt_arb_pkg::*;
#(
    parameter int N        = 4,
    parameter int SEL_BITS = sel_bits_f(N)
) (
    input  logic [N-1:0]        req,
    input  logic [SEL_BITS-1:0] ptr,
    input  logic [N-1:0]        mask,
    output logic                grant_vld,
    output logic [SEL_BITS-1:0] grant_idx
);

    logic [N-1:0]        cand;
    logic [SEL_BITS-1:0] idx;

    assign cand = req & mask;

    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        idx       = '0;
        // Scan farthest-first so the nearest candidate after ptr is the last one written.
        for (int k = N; k >= 1; k--) begin
            idx = SEL_BITS'((int'(ptr) + k) % N);
            if (cand[idx]) begin
                grant_vld = 1'b1;
                grant_idx = idx;
            end
        end
    end

endmodule

// File: rtl/pkt_in_arbiter.sv
// Round-robin merge of NUM_INPUTS packet streams into one registered router input.
// Optional PKT_ARB_PRIO_EN adds prio_in: prioritised requesters win, same rotating pointer.
module pkt_in_arbiter
    import pkt_arb_pkg::*;
#(
    parameter int PACKET_BITS = PKT_BITS_DEFAULT,
    parameter int NUM_INPUTS  = 4,
    parameter int SEL_BITS    = sel_bits_f(NUM_INPUTS)
) (
    input  logic                  clk,
    input  logic                  resetn,
    pkt_in_arbiter_if.master      bus,
`ifdef PKT_ARB_PRIO_EN
    input  logic [NUM_INPUTS-1:0] prio_in,
`endif
    output logic [NUM_INPUTS-1:0] arb_cnt_out,
    output logic [SEL_BITS-1:0]   last_grant_out
);

    logic [NUM_INPUTS-1:0]  req;
    logic [NUM_INPUTS-1:0]  mask;
    logic                   grant_vld;
    logic [SEL_BITS-1:0]    grant_idx;
    logic                   load_ok;
    logic                   accept;
    logic [PACKET_BITS-1:0] out_data_p1;
    logic                   out_vld_p1;

    always_comb begin
        req = '0;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            req[i] = bus.pkt_in_vld_in[i];
        end
    end

`ifdef PKT_ARB_PRIO_EN
    assign mask = (|(req & prio_in)) ? prio_in : '1;
`else
    assign mask = '1;
`endif

    rr_grant #(
        .N        (NUM_INPUTS),
        .SEL_BITS (SEL_BITS)
    ) u_rr_grant (
        .req       (req),
        .ptr       (last_grant_out),
        .mask      (mask),
        .grant_vld (grant_vld),
        .grant_idx (grant_idx)
    );

    assign load_ok = !out_vld_p1 || bus.pkt_out_rdy_in;
    // resetn gates ready so nothing is offered while the block is held in reset.
    assign accept  = resetn && load_ok && grant_vld;

    always_comb begin
        for (int i = 0; i < NUM_INPUTS; i++) begin
            bus.pkt_in_rdy_out[i] = accept && (grant_idx == SEL_BITS'(i));
        end
    end

    // Output register stage: one packet held toward the router.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            out_data_p1    <= '0;
            out_vld_p1     <= 1'b0;
            arb_cnt_out    <= '0;
            last_grant_out <= SEL_BITS'(NUM_INPUTS - 1);
        end else begin
            arb_cnt_out <= '0;
            if (accept) begin
                out_data_p1            <= bus.pkt_in_data_in[grant_idx];
                out_vld_p1             <= 1'b1;
                last_grant_out         <= grant_idx;
                arb_cnt_out[grant_idx] <= 1'b1;
            end else if (out_vld_p1 && bus.pkt_out_rdy_in) begin
                out_vld_p1 <= 1'b0;
            end
        end
    end

    assign bus.pkt_out_data_out = out_data_p1;
    assign bus.pkt_out_vld_out  = out_vld_p1;

endmodule

// File: tb/tb_pkt_in_arbiter.sv
// Scoreboard bench for pkt_in_arbiter with NUM_INPUTS=4; prio scenario runs when PKT_ARB_PRIO_EN is defined.
module tb_pkt_in_arbiter;

    localparam int PB = 72;
    localparam int NI = 4;
    localparam int SB = 2;

    logic          clk = 1'b0;
    logic          resetn;
    logic [NI-1:0] arb_cnt;
    logic [SB-1:0] last_grant;
`ifdef PKT_ARB_PRIO_EN
    logic [NI-1:0] prio_in;
`endif

    int            checks = 0;
    int            errors = 0;
    logic [PB-1:0] exp_q[$];

    pkt_in_arbiter_if #(.PACKET_BITS(PB), .NUM_INPUTS(NI)) bus ();

    pkt_in_arbiter #(.PACKET_BITS(PB), .NUM_INPUTS(NI)) dut (
        .clk            (clk),
        .resetn         (resetn),
        .bus            (bus.master),
`ifdef PKT_ARB_PRIO_EN
        .prio_in        (prio_in),
`endif
        .arb_cnt_out    (arb_cnt),
        .last_grant_out (last_grant)
    );

    always #5 clk = ~clk;

    function automatic logic [NI-1:0] rdy_vec();
        logic [NI-1:0] r;
        for (int i = 0; i < NI; i++) r[i] = bus.pkt_in_rdy_out[i];
        return r;
    endfunction

    task automatic set_in(input int i, input logic v, input logic [PB-1:0] d);
        for (int j = 0; j < NI; j++) begin
            if (j == i) begin
                bus.pkt_in_vld_in[j]  = v;
                bus.pkt_in_data_in[j] = d;
            end
        end
    endtask

    // One clock: record the accept (pushing the driven data as expected output) and the consume.
    task automatic tick(output int acc, output int nrdy, output bit cons, output logic [PB-1:0] cd);
        #1;
        acc  = -1;
        nrdy = 0;
        for (int i = 0; i < NI; i++) begin
            if (bus.pkt_in_rdy_out[i]) begin
                nrdy++;
                if (bus.pkt_in_vld_in[i]) begin
                    acc = i;
                    exp_q.push_back(bus.pkt_in_data_in[i]);
                end
            end
        end
        cons = bus.pkt_out_vld_out && bus.pkt_out_rdy_in;
        cd   = bus.pkt_out_data_out;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        resetn             = 1'b0;
        bus.pkt_out_rdy_in = 1'b0;
`ifdef PKT_ARB_PRIO_EN
        prio_in = '0;
`endif
        for (int i = 0; i < NI; i++) set_in(i, 1'b1, PB'(8'h10 + i));
        #12;
        checks++;
        if (bus.pkt_out_vld_out !== 1'b0 || bus.pkt_out_data_out !== '0) begin
            errors++; $display("FAIL reset_out: vld %b data 0x%0h, expected 0 / 0", bus.pkt_out_vld_out, bus.pkt_out_data_out);
        end
        checks++;
        if (arb_cnt !== '0) begin errors++; $display("FAIL reset_cnt: got %b, expected 0000", arb_cnt); end
        checks++;
        if (last_grant !== SB'(NI - 1)) begin errors++; $display("FAIL reset_last_grant: got %0d, expected %0d", last_grant, NI - 1); end
        checks++;
        if (rdy_vec() !== '0) begin errors++; $display("FAIL reset_rdy: got %b, expected 0000", rdy_vec()); end
        for (int i = 0; i < NI; i++) set_in(i, 1'b0, '0);
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_round_robin();
        int acc, nrdy; bit cons; logic [PB-1:0] cd, exp;
        bus.pkt_out_rdy_in = 1'b1;
        for (int i = 0; i < NI; i++) set_in(i, 1'b1, PB'(8'hA0 + i));
        for (int k = 0; k < 8; k++) begin
            tick(acc, nrdy, cons, cd);
            checks++;
            if (acc != k % NI || nrdy != 1) begin errors++; $display("FAIL rr_grant: accepted %0d (rdy count %0d), expected %0d", acc, nrdy, k % NI); end
            checks++;
            if (arb_cnt !== NI'(1 << (k % NI))) begin errors++; $display("FAIL rr_cnt: got %b, expected %b", arb_cnt, NI'(1 << (k % NI))); end
            checks++;
            if (last_grant !== SB'(k % NI)) begin errors++; $display("FAIL rr_last_grant: got %0d, expected %0d", last_grant, k % NI); end
            checks++;
            if (bus.pkt_out_vld_out !== 1'b1 || bus.pkt_out_data_out !== PB'(8'hA0 + k % NI)) begin
                errors++; $display("FAIL rr_out: vld %b data 0x%0h, expected 1 / 0x%0h", bus.pkt_out_vld_out, bus.pkt_out_data_out, 8'hA0 + k % NI);
            end
            checks++;
            if (cons !== (k > 0)) begin errors++; $display("FAIL rr_bubble: consume %b, expected %b", cons, k > 0); end
            if (cons) begin
                checks++;
                if (exp_q.size() == 0) begin errors++; $display("FAIL rr_sb: got 0x%0h, scoreboard empty", cd); end
                else begin exp = exp_q.pop_front(); if (cd !== exp) begin errors++; $display("FAIL rr_sb: got 0x%0h, expected 0x%0h", cd, exp); end end
            end
        end
        for (int i = 0; i < NI; i++) set_in(i, 1'b0, '0);
        tick(acc, nrdy, cons, cd);
        checks++;
        if (!cons || exp_q.size() != 1) begin errors++; $display("FAIL rr_drain: consume %b queue %0d, expected 1 / 1", cons, exp_q.size()); end
        else begin exp = exp_q.pop_front(); if (cd !== exp) begin errors++; $display("FAIL rr_drain: got 0x%0h, expected 0x%0h", cd, exp); end end
        checks++;
        if (bus.pkt_out_vld_out !== 1'b0 || arb_cnt !== '0) begin errors++; $display("FAIL rr_idle: vld %b cnt %b, expected 0 / 0000", bus.pkt_out_vld_out, arb_cnt); end
    endtask

    task automatic test_backpressure();
        int acc, nrdy; bit cons; logic [PB-1:0] cd, exp;
        logic [PB-1:0] seq_exp[3];
        seq_exp[0] = PB'(8'hB1); seq_exp[1] = PB'(8'hB2); seq_exp[2] = PB'(8'hB3);
        bus.pkt_out_rdy_in = 1'b0;
        set_in(1, 1'b1, PB'(8'hB1));
        set_in(2, 1'b1, PB'(8'hB2));
        tick(acc, nrdy, cons, cd);
        checks++;
        if (acc != 1) begin errors++; $display("FAIL bp_first: accepted %0d, expected 1", acc); end
        set_in(1, 1'b1, PB'(8'hB3));
        for (int k = 0; k < 5; k++) begin
            tick(acc, nrdy, cons, cd);
            checks++;
            if (nrdy != 0) begin errors++; $display("FAIL bp_rdy: rdy count %0d, expected 0", nrdy); end
            checks++;
            if (bus.pkt_out_vld_out !== 1'b1 || bus.pkt_out_data_out !== PB'(8'hB1)) begin
                errors++; $display("FAIL bp_hold: vld %b data 0x%0h, expected 1 / 0xb1", bus.pkt_out_vld_out, bus.pkt_out_data_out);
            end
            checks++;
            if (last_grant !== SB'(1) || arb_cnt !== '0) begin errors++; $display("FAIL bp_ptr: last %0d cnt %b, expected 1 / 0000", last_grant, arb_cnt); end
        end
        bus.pkt_out_rdy_in = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick(acc, nrdy, cons, cd);
            checks++;
            if (acc != ((k == 0) ? 2 : (k == 1) ? 1 : -1)) begin errors++; $display("FAIL bp_order: step %0d accepted %0d", k, acc); end
            checks++;
            if (!cons || exp_q.size() == 0) begin errors++; $display("FAIL bp_sb: consume %b queue %0d at step %0d", cons, exp_q.size(), k); end
            else begin
                exp = exp_q.pop_front();
                if (cd !== exp || cd !== seq_exp[k]) begin errors++; $display("FAIL bp_sb: got 0x%0h, expected 0x%0h", cd, seq_exp[k]); end
            end
            if (k == 0) set_in(2, 1'b0, '0);
            if (k == 1) set_in(1, 1'b0, '0);
        end
    endtask

    task automatic test_single();
        int acc, nrdy; bit cons; logic [PB-1:0] cd, exp;
        bus.pkt_out_rdy_in = 1'b1;
        for (int k = 0; k < 10; k++) begin
            set_in(3, 1'b1, PB'(12'h300 + k));
            tick(acc, nrdy, cons, cd);
            checks++;
            if (acc != 3 || last_grant !== SB'(3) || arb_cnt !== 4'b1000) begin
                errors++; $display("FAIL single_grant: acc %0d last %0d cnt %b, expected 3 / 3 / 1000", acc, last_grant, arb_cnt);
            end
            checks++;
            if (bus.pkt_out_vld_out !== 1'b1 || bus.pkt_out_data_out !== PB'(12'h300 + k) || cons !== (k > 0)) begin
                errors++; $display("FAIL single_out: vld %b data 0x%0h consume %b, expected 1 / 0x%0h / %b", bus.pkt_out_vld_out, bus.pkt_out_data_out, cons, 12'h300 + k, k > 0);
            end
            if (cons) begin
                checks++;
                if (exp_q.size() == 0) begin errors++; $display("FAIL single_sb: got 0x%0h, scoreboard empty", cd); end
                else begin exp = exp_q.pop_front(); if (cd !== exp) begin errors++; $display("FAIL single_sb: got 0x%0h, expected 0x%0h", cd, exp); end end
            end
        end
        set_in(3, 1'b0, '0);
        tick(acc, nrdy, cons, cd);
        checks++;
        if (!cons || exp_q.size() != 1) begin errors++; $display("FAIL single_drain: consume %b queue %0d, expected 1 / 1", cons, exp_q.size()); end
        else begin exp = exp_q.pop_front(); if (cd !== exp) begin errors++; $display("FAIL single_drain: got 0x%0h, expected 0x%0h", cd, exp); end end
    endtask

`ifdef PKT_ARB_PRIO_EN
    task automatic test_prio();
        int acc, nrdy; bit cons; logic [PB-1:0] cd, exp;
        int exp_acc;
        bus.pkt_out_rdy_in = 1'b1;
        for (int i = 0; i < NI; i++) set_in(i, 1'b1, PB'(8'hD0 + i));
        prio_in = 4'b0100;
        for (int k = 0; k < 9; k++) begin
            if (k == 5) prio_in = '0;
            if (k == 7) for (int i = 0; i < NI; i++) set_in(i, 1'b0, '0);
            exp_acc = (k < 5) ? 2 : (k == 5) ? 3 : (k == 6) ? 0 : -1;
            tick(acc, nrdy, cons, cd);
            checks++;
            if (acc != exp_acc) begin errors++; $display("FAIL prio_grant: step %0d accepted %0d, expected %0d", k, acc, exp_acc); end
            if (cons) begin
                checks++;
                if (exp_q.size() == 0) begin errors++; $display("FAIL prio_sb: got 0x%0h, scoreboard empty", cd); end
                else begin exp = exp_q.pop_front(); if (cd !== exp) begin errors++; $display("FAIL prio_sb: got 0x%0h, expected 0x%0h", cd, exp); end end
            end
        end
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL prio_left: %0d packets left, expected 0", exp_q.size()); end
    endtask
`endif

    task automatic test_back_to_back();
        int acc, nrdy; bit cons, stalled; logic [PB-1:0] cd, exp, d;
        int seq[NI]; int waitg[NI]; int maxw; int both; logic [NI-1:0] vpre;
        maxw = 0; both = 0;
        for (int i = 0; i < NI; i++) begin seq[i] = 0; waitg[i] = 0; end
        for (int c = 0; c < 400; c++) begin
            bus.pkt_out_rdy_in = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < NI; i++) begin
                if (!bus.pkt_in_vld_in[i] && $urandom_range(0, 1) == 1) begin
                    d = '0; d[39:32] = 8'(i); d[31:0] = 32'(seq[i]);
                    set_in(i, 1'b1, d);
                end
                vpre[i] = bus.pkt_in_vld_in[i];
            end
            stalled = bus.pkt_out_vld_out && !bus.pkt_out_rdy_in;
            tick(acc, nrdy, cons, cd);
            checks++;
            if (nrdy > 1 || (stalled && nrdy != 0)) begin errors++; $display("FAIL b2b_rdy: rdy count %0d stalled %b", nrdy, stalled); end
            checks++;
            if (arb_cnt !== ((acc >= 0) ? NI'(1 << acc) : NI'(0))) begin errors++; $display("FAIL b2b_cnt: got %b for accept %0d", arb_cnt, acc); end
            if (acc >= 0) begin
                checks++;
                if (last_grant !== SB'(acc) || bus.pkt_out_vld_out !== 1'b1) begin
                    errors++; $display("FAIL b2b_load: last %0d vld %b, expected %0d / 1", last_grant, bus.pkt_out_vld_out, acc);
                end
                if (cons) both++;
                for (int i = 0; i < NI; i++) begin
                    if (i == acc) waitg[i] = 0;
                    else if (vpre[i]) begin waitg[i]++; if (waitg[i] > maxw) maxw = waitg[i]; end
                end
                seq[acc]++;
                d = '0; d[39:32] = 8'(acc); d[31:0] = 32'(seq[acc]);
                set_in(acc, ($urandom_range(0, 1) == 1), d);
            end
            if (cons) begin
                checks++;
                if (exp_q.size() == 0) begin errors++; $display("FAIL b2b_sb: got 0x%0h, scoreboard empty", cd); end
                else begin exp = exp_q.pop_front(); if (cd !== exp) begin errors++; $display("FAIL b2b_sb: got 0x%0h, expected 0x%0h", cd, exp); end end
            end
        end
        for (int i = 0; i < NI; i++) set_in(i, 1'b0, '0);
        bus.pkt_out_rdy_in = 1'b1;
        for (int c = 0; c < 4 && exp_q.size() > 0; c++) begin
            tick(acc, nrdy, cons, cd);
            if (cons) begin
                checks++;
                exp = exp_q.pop_front();
                if (cd !== exp) begin errors++; $display("FAIL b2b_drain: got 0x%0h, expected 0x%0h", cd, exp); end
            end
        end
        checks++;
        if (exp_q.size() != 0 || both == 0) begin errors++; $display("FAIL b2b_end: %0d packets left, %0d consume+accept cycles", exp_q.size(), both); end
        checks++;
        if (maxw > NI - 1) begin errors++; $display("FAIL b2b_fair: waited %0d grants, limit %0d", maxw, NI - 1); end
    endtask

    task automatic test_reset_mid();
        int acc, nrdy; bit cons; logic [PB-1:0] cd, exp;
        bus.pkt_out_rdy_in = 1'b0;
        set_in(0, 1'b1, PB'(8'hC0));
        tick(acc, nrdy, cons, cd);
        checks++;
        if (acc != 0 || bus.pkt_out_vld_out !== 1'b1) begin errors++; $display("FAIL rst_mid_load: accepted %0d vld %b, expected 0 / 1", acc, bus.pkt_out_vld_out); end
        #2;
        resetn = 1'b0;
        #1;
        checks++;
        if (bus.pkt_out_vld_out !== 1'b0 || bus.pkt_out_data_out !== '0 || arb_cnt !== '0 || rdy_vec() !== '0) begin
            errors++; $display("FAIL rst_mid_clear: vld %b data 0x%0h cnt %b rdy %b, expected all zero", bus.pkt_out_vld_out, bus.pkt_out_data_out, arb_cnt, rdy_vec());
        end
        checks++;
        if (last_grant !== SB'(NI - 1)) begin errors++; $display("FAIL rst_mid_ptr: got %0d, expected %0d", last_grant, NI - 1); end
        exp_q.delete();
        set_in(0, 1'b0, '0);
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk);
        #1;
        bus.pkt_out_rdy_in = 1'b1;
        set_in(0, 1'b1, PB'(8'hC1));
        set_in(2, 1'b1, PB'(8'hC2));
        for (int k = 0; k < 3; k++) begin
            tick(acc, nrdy, cons, cd);
            checks++;
            if (acc != ((k == 0) ? 0 : (k == 1) ? 2 : -1)) begin errors++; $display("FAIL rst_mid_order: step %0d accepted %0d", k, acc); end
            if (k > 0) begin
                checks++;
                if (!cons || exp_q.size() == 0) begin errors++; $display("FAIL rst_mid_sb: consume %b queue %0d at step %0d", cons, exp_q.size(), k); end
                else begin
                    exp = exp_q.pop_front();
                    if (cd !== exp || cd !== PB'((k == 1) ? 8'hC1 : 8'hC2)) begin errors++; $display("FAIL rst_mid_sb: got 0x%0h at step %0d", cd, k); end
                end
            end
            if (k == 0) set_in(0, 1'b0, '0);
            if (k == 1) set_in(2, 1'b0, '0);
        end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_backpressure();
        test_single();
`ifdef PKT_ARB_PRIO_EN
        test_prio();
`endif
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time %0t reached limit 200000 before completion", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
